// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, flag bit indices and flag struct shared by alu_pipe and its core
package alu_pkg;
    typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_NOT, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_EQ} op_e;
    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 3;
    typedef struct packed {
        logic n;
        logic v;
        logic c;
        logic z;
    } flags_t;
endpackage

// File: rtl/alu_pipe_core.sv
// alu_pipe_core: combinational WIDTH-bit op evaluation with Z/C/V/N flags
module alu_pipe_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  op_e              i_op,
    output logic [WIDTH-1:0] o_res,
    output flags_t           o_flags
);
    logic             w_sub;
    logic             w_arith;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH:0]   w_sum;
    logic [3:0]       w_f;

    assign w_sub   = i_op == OP_SUB;
    assign w_arith = w_sub || i_op == OP_ADD;
    assign w_b     = w_sub ? ~i_b : i_b;
    assign w_sum   = {1'b0, i_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_sub};

    always_comb begin
        o_res = '0;
        case (i_op)
            OP_ADD, OP_SUB: o_res = w_sum[WIDTH-1:0];
            OP_NOT:         o_res = ~i_a;
            OP_AND:         o_res = i_a & i_b;
            OP_OR:          o_res = i_a | i_b;
            OP_XOR:         o_res = i_a ^ i_b;
            OP_SLT:         o_res = {{(WIDTH-1){1'b0}}, $signed(i_a) < $signed(i_b)};
            default:        o_res = {{(WIDTH-1){1'b0}}, i_a == i_b};
        endcase
    end

    // overflow compares against the effective second operand, so SUB sees ~B
    always_comb begin
        w_f         = '0;
        w_f[FLAG_Z] = o_res == '0;
        w_f[FLAG_N] = o_res[WIDTH-1];
        w_f[FLAG_C] = w_arith && w_sum[WIDTH];
        w_f[FLAG_V] = w_arith && (i_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
    end

    assign o_flags = flags_t'(w_f);
endmodule

// File: rtl/bcd7seg.sv
// bcd7seg: hex digit to active-low 7-segment pattern {g,f,e,d,c,b,a}
// Only built when ALU_SEG_EN is defined.
`ifdef ALU_SEG_EN
module bcd7seg (
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);
    always_comb begin
        o_seg = 7'h7f;
        case (i_hex)
            4'h0: o_seg = 7'h40;
            4'h1: o_seg = 7'h79;
            4'h2: o_seg = 7'h24;
            4'h3: o_seg = 7'h30;
            4'h4: o_seg = 7'h19;
            4'h5: o_seg = 7'h12;
            4'h6: o_seg = 7'h02;
            4'h7: o_seg = 7'h78;
            4'h8: o_seg = 7'h00;
            4'h9: o_seg = 7'h10;
            4'ha: o_seg = 7'h08;
            4'hb: o_seg = 7'h03;
            4'hc: o_seg = 7'h46;
            4'hd: o_seg = 7'h21;
            4'he: o_seg = 7'h06;
            default: o_seg = 7'h0e;
        endcase
    end
endmodule
`endif

// File: rtl/alu_pipe.sv
// alu_pipe: valid/ready pipelined ALU with a 2-entry registered skid buffer (O + S)
// Optional 7-segment output of out_res[3:0] when ALU_SEG_EN is defined.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic [3:0]       out_flags
`ifdef ALU_SEG_EN
    , output logic [6:0]     seg
`endif
);
    logic [WIDTH-1:0] w_res;
    flags_t           w_flags;
    logic             w_acc;
    logic             w_drain;
    logic             w_load_o;
    logic             w_load_s;
    logic [WIDTH-1:0] w_o_res;
    flags_t           w_o_flags;

    logic             r_o_valid;
    logic [WIDTH-1:0] r_o_res;
    flags_t           r_o_flags;
    logic             r_s_valid;
    logic [WIDTH-1:0] r_s_res;
    flags_t           r_s_flags;

    alu_pipe_core #(.WIDTH(WIDTH)) u_core (
        .i_a     (in_a),
        .i_b     (in_b),
        .i_op    (op_e'(in_op)),
        .o_res   (w_res),
        .o_flags (w_flags)
    );

    // S full blocks new requests, so a drain never coincides with an accept
    assign w_acc     = in_valid && !r_s_valid;
    assign w_drain   = r_s_valid && out_ready;
    assign w_load_o  = w_drain || (w_acc && (!r_o_valid || out_ready));
    assign w_load_s  = w_acc && r_o_valid && !out_ready;
    assign w_o_res   = r_s_valid ? r_s_res : w_res;
    assign w_o_flags = r_s_valid ? r_s_flags : w_flags;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_o_valid <= 1'b0;
            r_o_res   <= '0;
            r_o_flags <= '0;
            r_s_valid <= 1'b0;
            r_s_res   <= '0;
            r_s_flags <= '0;
        end else begin
            r_o_valid <= w_load_o || (r_o_valid && !out_ready);
            if (w_load_o) begin
                r_o_res   <= w_o_res;
                r_o_flags <= w_o_flags;
            end
            if (w_drain) begin
                r_s_valid <= 1'b0;
            end else if (w_load_s) begin
                r_s_valid <= 1'b1;
                r_s_res   <= w_res;
                r_s_flags <= w_flags;
            end
        end
    end

    assign in_ready  = !r_s_valid;
    assign out_valid = r_o_valid;
    assign out_res   = r_o_res;
    assign out_flags = r_o_flags;

`ifdef ALU_SEG_EN
    logic [6:0] w_seg;
    logic [6:0] r_seg;

    bcd7seg u_seg (
        .i_hex (4'(w_o_res)),
        .o_seg (w_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= 7'h40;
        end else if (w_load_o) begin
            r_seg <= w_seg;
        end
    end

    assign seg = r_seg;
`endif
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vector table, backpressure/reset sequences and a random stream
// checked against an arithmetic reference model with an in-order scoreboard.
module tb_alu_pipe;
    import alu_pkg::*;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic [2:0]   in_op = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_res;
    logic [3:0]   out_flags;

    int   vectors = 0;
    int   miscompares = 0;
    int   n_out = 0;
    bit   mon_en = 1'b0;
    bit   done = 1'b0;
    logic [7:0] q[$];

    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
        logic [3:0] flags;
    } vec_t;
    vec_t tbl[13];

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_flags (out_flags)
    );

    // returns {N,V,C,Z,res} from integer arithmetic on the operand values
    function automatic logic [7:0] ref_alu(logic [2:0] op, logic [3:0] a, logic [3:0] b);
        int ua = int'(a);
        int ub = int'(b);
        int sa = ua > 7 ? ua - 16 : ua;
        int sb = ub > 7 ? ub - 16 : ub;
        int r = 0;
        int sv = 0;
        bit c = 1'b0;
        bit v = 1'b0;
        case (op)
            OP_ADD: begin r = ua + ub; c = r > 15; sv = sa + sb; v = sv > 7 || sv < -8; end
            OP_SUB: begin r = ua - ub; c = ua >= ub; sv = sa - sb; v = sv > 7 || sv < -8; end
            OP_NOT: r = 15 - ua;
            OP_AND: r = ua & ub;
            OP_OR:  r = ua | ub;
            OP_XOR: r = ua ^ ub;
            OP_SLT: r = sa < sb ? 1 : 0;
            default: r = ua == ub ? 1 : 0;
        endcase
        r = r & 15;
        return {r > 7, v, c, r == 0, 4'(r)};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(logic [2:0] op, logic [3:0] a, logic [3:0] b);
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_op = op;
        in_a = a;
        in_b = b;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            tick();
        end
        in_valid = 1'b0;
        check("send_accept", 32'(acc), 32'd1);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 30 && q.size() != 0; i++) tick();
        tick();
        check("drain_empty", q.size(), 0);
    endtask

    // scoreboard: head of queue must be on the output whenever it is valid
    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst_n) begin
                q.delete();
            end else begin
                if (out_valid) begin
                    if (q.size() == 0) begin
                        check("spurious_out", {24'd0, out_flags, out_res}, 32'hffff_ffff);
                    end else begin
                        check("sb_result", {24'd0, out_flags, out_res}, {24'd0, q[0]});
                        if (out_ready) begin
                            void'(q.pop_front());
                            n_out++;
                        end
                    end
                end
                if (in_valid && in_ready) q.push_back(ref_alu(in_op, in_a, in_b));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{OP_ADD, 4'h7, 4'h9, 4'h0, 4'b0011};
        tbl[1]  = '{OP_ADD, 4'h7, 4'h1, 4'h8, 4'b1100};
        tbl[2]  = '{OP_SUB, 4'h4, 4'h5, 4'hf, 4'b1000};
        tbl[3]  = '{OP_SUB, 4'h5, 4'h5, 4'h0, 4'b0011};
        tbl[4]  = '{OP_SLT, 4'h8, 4'h1, 4'h1, 4'b0000};
        tbl[5]  = '{OP_EQ,  4'h3, 4'h3, 4'h1, 4'b0000};
        tbl[6]  = '{OP_EQ,  4'h3, 4'h4, 4'h0, 4'b0001};
        tbl[7]  = '{OP_NOT, 4'h5, 4'h0, 4'ha, 4'b1000};
        tbl[8]  = '{OP_AND, 4'hc, 4'ha, 4'h8, 4'b1000};
        tbl[9]  = '{OP_OR,  4'h5, 4'ha, 4'hf, 4'b1000};
        tbl[10] = '{OP_XOR, 4'hf, 4'hf, 4'h0, 4'b0001};
        tbl[11] = '{OP_SLT, 4'h1, 4'h8, 4'h0, 4'b0001};
        tbl[12] = '{OP_SUB, 4'h8, 4'h1, 4'h7, 4'b0110};

        #3;
        check("reset_state", {27'd0, out_valid, in_ready, out_res != 0, out_flags != 0}, 32'b0100);
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 13; i++) begin
            in_valid = 1'b1;
            in_op = tbl[i].op;
            in_a = tbl[i].a;
            in_b = tbl[i].b;
            tick();
            check($sformatf("tbl%0d", i), {23'd0, out_valid, out_flags, out_res},
                  {23'd0, 1'b1, tbl[i].flags, tbl[i].res});
        end
        in_valid = 1'b0;
        tick();
        check("idle_after_tbl", 32'(out_valid), 32'd0);

        mon_en = 1'b1;
        n_out = 0;
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = OP_ADD; in_a = 4'h1; in_b = 4'h2;
        tick();
        check("bp_ready_after_1", 32'(in_ready), 32'd1);
        in_op = OP_SUB; in_a = 4'h3; in_b = 4'h5;
        tick();
        check("bp_ready_after_2", 32'(in_ready), 32'd0);
        in_op = OP_XOR; in_a = 4'h6; in_b = 4'h3;
        tick();
        check("bp_ready_held", 32'(in_ready), 32'd0);
        check("bp_out_first", {27'd0, out_valid, out_res}, {27'd0, 1'b1, 4'h3});
        out_ready = 1'b1;
        tick();
        check("bp_ready_reassert", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        drain();
        check("bp_count", n_out, 3);

        n_out = 0;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    if ($urandom_range(0, 3) == 0) tick();
                    send(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        drain();
        check("stream_count", n_out, 16);

        out_ready = 1'b0;
        send(OP_ADD, 4'h4, 4'h4);
        send(OP_OR, 4'h1, 4'h2);
        check("rst_s_full", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", {28'd0, out_valid, in_ready, out_res != 0, out_flags != 0}, 32'b0100);
        tick();
        check("rst_held", {28'd0, out_valid, in_ready, out_res != 0, out_flags != 0}, 32'b0100);
        rst_n = 1'b1;
        out_ready = 1'b1;
        n_out = 0;
        tick();
        send(OP_ADD, 4'h2, 4'h3);
        check("post_rst_result", {27'd0, out_valid, out_res}, {27'd0, 1'b1, 4'h5});
        drain();
        check("post_rst_count", n_out, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
